// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the ADC decimation stage.
package adc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    localparam int unsigned DROP_CNT_W = 8;

    // Sum of 2**decim_log2 words of resolution bits never exceeds resolution+decim_log2 bits.
    function automatic int unsigned acc_w(input int unsigned resolution,
                                          input int unsigned decim_log2);
        return resolution + decim_log2;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/adc_decimator.sv
// Boxcar-averages 2**DECIM_LOG2 ADC samples per window and offers each mean on a
// valid/ready port; windows arriving while the port is stalled are dropped and counted.
module adc_decimator
    import adc_pkg::*;
#(
    parameter int unsigned RESOLUTION = 10,
    parameter int unsigned DECIM_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [RESOLUTION-1:0] adc_in,
    input  logic                  adc_underflow,
    input  logic                  adc_overflow,
    output logic [RESOLUTION-1:0] sample_data,
    output logic                  sample_clip,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic [DROP_CNT_W-1:0] dropped_count,
    output logic                  busy
);

    localparam int unsigned ACC_W = acc_w(RESOLUTION, DECIM_LOG2);

    state_e                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]      sum;
    logic [DECIM_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic                  clip_acc_q, clip_acc_d;
    logic [RESOLUTION-1:0] data_q, data_d;
    logic                  clip_q, clip_d;
    logic                  valid_q, valid_d;
    logic                  flag;
    logic                  win_done;
    logic                  drop;

    assign flag = adc_underflow | adc_overflow;
    assign sum  = acc_q + ACC_W'(adc_in);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        win_cnt_d  = win_cnt_q;
        clip_acc_d = clip_acc_q;
        win_done   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_ACCUM;
                    acc_d      = ACC_W'(adc_in);
                    win_cnt_d  = DECIM_LOG2'(1);
                    clip_acc_d = flag;
                end
            end
            ST_ACCUM: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    acc_d      = '0;
                    win_cnt_d  = '0;
                    clip_acc_d = 1'b0;
                end else if (&win_cnt_q) begin
                    // Last sample of the window: restart from zero so the next one has no gap.
                    win_done   = 1'b1;
                    acc_d      = '0;
                    win_cnt_d  = '0;
                    clip_acc_d = 1'b0;
                end else begin
                    acc_d      = sum;
                    win_cnt_d  = win_cnt_q + DECIM_LOG2'(1);
                    clip_acc_d = clip_acc_q | flag;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        clip_d  = clip_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (win_done) begin
            if (!valid_q || sample_ready) begin
                data_d  = RESOLUTION'(sum >> DECIM_LOG2);
                clip_d  = clip_acc_q | flag;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            win_cnt_q  <= '0;
            clip_acc_q <= 1'b0;
            data_q     <= '0;
            clip_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            win_cnt_q  <= win_cnt_d;
            clip_acc_q <= clip_acc_d;
            data_q     <= data_d;
            clip_q     <= clip_d;
            valid_q    <= valid_d;
        end
    end

    sat_counter #(
        .WIDTH(DROP_CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(1'b0),
        .inc  (drop),
        .count(dropped_count)
    );

    assign sample_data  = data_q;
    assign sample_clip  = clip_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q == ST_ACCUM);

endmodule
